// File: rtl/adder_pkg.sv
// Shared constants and result payload for the datapath adder-comparison set.
package adder_pkg;

   localparam int unsigned ADDER_WIDTH = 32;
   localparam int unsigned GROUP_W     = 4;
   localparam int unsigned NUM_GROUPS  = ADDER_WIDTH / GROUP_W;

   typedef struct packed {
      logic [ADDER_WIDTH-1:0] sum;
      logic                   cout;
      logic                   ovf;
   } adder_result_t;

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group with group propagate/generate outputs.
module cla4_group
   import adder_pkg::*;
(
   input  logic [GROUP_W-1:0] a,
   input  logic [GROUP_W-1:0] b,
   input  logic               ci,
   output logic [GROUP_W-1:0] s,
   output logic               co,
   output logic               P,
   output logic               G
);

   logic [GROUP_W-1:0] w_g;
   logic [GROUP_W-1:0] w_p;
   logic [GROUP_W-1:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Flattened lookahead: every internal carry depends only on g/p and ci.
   always_comb begin
      w_c    = '0;
      w_c[0] = ci;
      w_c[1] = w_g[0] | (w_p[0] & ci);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & ci);
   end

   assign G  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign P  = &w_p;
   assign co = G | (P & ci);
   assign s  = w_p ^ w_c;

endmodule

// File: rtl/cia32_cla.sv
// Registered 32-bit carry-increment adder: CLA groups plus per-group incrementers.
module cia32_cla
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADDER_WIDTH,
   parameter int unsigned GROUP = GROUP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   localparam int unsigned NG = WIDTH / GROUP;

   logic [NG:0]      w_c;
   logic [NG-1:0]    w_p;
   logic [NG-1:0]    w_g;
   logic [NG-1:0]    w_co;
   logic [WIDTH-1:0] w_ps;
   logic [WIDTH-1:0] w_s;
   logic             w_ovf;
   logic             w_unused;
   adder_result_t    w_res;
   adder_result_t    r_res;
   logic             r_valid;

   assign w_c[0] = cin;

   // Groups above 0 add with carry-in 0; the true group carry is applied afterwards.
   for (genvar k = 0; k < NG; k++) begin : g_grp
      if (k == 0) begin : g_lsb
         cla4_group u_cla (
            .a  (a[k*GROUP +: GROUP]),
            .b  (b[k*GROUP +: GROUP]),
            .ci (cin),
            .s  (w_ps[k*GROUP +: GROUP]),
            .co (w_co[k]),
            .P  (w_p[k]),
            .G  (w_g[k])
         );
         assign w_s[k*GROUP +: GROUP] = w_ps[k*GROUP +: GROUP];
         assign w_c[k+1]              = w_co[k];
      end else begin : g_inc
         cla4_group u_cla (
            .a  (a[k*GROUP +: GROUP]),
            .b  (b[k*GROUP +: GROUP]),
            .ci (1'b0),
            .s  (w_ps[k*GROUP +: GROUP]),
            .co (w_co[k]),
            .P  (w_p[k]),
            .G  (w_g[k])
         );
         assign w_s[k*GROUP +: GROUP] = w_ps[k*GROUP +: GROUP] + GROUP'(w_c[k]);
         assign w_c[k+1]              = w_g[k] | (w_p[k] & w_c[k]);
      end
   end

   // With ci=0 the upper-group co equals G, and group 0 uses co directly.
   assign w_unused = &{1'b0, w_g[0], w_co[NG-1:1]};

   assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (w_s[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      w_res      = '0;
      w_res.sum  = w_s;
      w_res.cout = w_c[NG];
      w_res.ovf  = w_ovf;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_res <= w_res;
         end
      end
   end

   assign sum       = r_res.sum;
   assign cout      = r_res.cout;
   assign ovf       = r_res.ovf;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_cia32_cla.sv
// Self-checking bench for cia32_cla: directed vectors, random stream, holds and async reset.
module tb_cia32_cla;

   typedef struct {
      logic        vld;
      logic [31:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] a        = '0;
   logic [31:0] b        = '0;
   logic        cin      = 1'b0;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic        out_valid;

   exp_t        sb_q[$];
   exp_t        push_e;
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_errors = 0;
   bit          pipe_en  = 1'b0;
   bit          mon_en   = 1'b0;
   logic [31:0] m_sum    = '0;
   logic        m_cout   = 1'b0;
   logic        m_ovf    = 1'b0;
   logic [32:0] m_full;
   logic [32:0] m_sx;

   cia32_cla dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference model: exact 33-bit unsigned sum, sign-extended sum for overflow.
   initial forever begin
      @(posedge clk);
      if (pipe_en && !rst) begin
         if (in_valid) begin
            m_full = {1'b0, a} + {1'b0, b} + 33'(cin);
            m_sx   = {a[31], a} + {b[31], b} + 33'(cin);
            m_sum  = m_full[31:0];
            m_cout = m_full[32];
            m_ovf  = m_sx[32] ^ m_sx[31];
         end
         push_e.vld = in_valid;
         push_e.s   = m_sum;
         push_e.c   = m_cout;
         push_e.o   = m_ovf;
         sb_q.push_back(push_e);
         mon_en = 1'b1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("sb_valid", 32'(out_valid), 32'(mon_e.vld));
            check_eq("sb_sum", sum, mon_e.s);
            check_eq("sb_cout", 32'(cout), 32'(mon_e.c));
            check_eq("sb_ovf", 32'(ovf), 32'(mon_e.o));
         end
      end
   end

   task automatic dir(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                      input logic xc, input logic [31:0] es, input logic ec, input logic eo);
      a        = xa;
      b        = xb;
      cin      = xc;
      in_valid = 1'b1;
      @(negedge clk);
      check_eq({tag, "_sum"}, sum, es);
      check_eq({tag, "_cout"}, 32'(cout), 32'(ec));
      check_eq({tag, "_ovf"}, 32'(ovf), 32'(eo));
      check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_sum"}, sum, 32'd0);
      check_eq({tag, "_cout"}, 32'(cout), 32'd0);
      check_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
      check_eq({tag, "_vld"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_zero("rst");
      rst     = 1'b0;
      pipe_en = 1'b1;

      dir("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      dir("negovf", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      dir("mix1",   32'h0000_0002, 32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0);
      dir("mix2",   32'hFFFF_FFFB, 32'hFFFF_FFF4, 1'b0, 32'hFFFF_FFEF, 1'b1, 1'b0);
      dir("pos12",  32'h0000_000C, 32'h0000_0019, 1'b0, 32'h0000_0025, 1'b0, 1'b0);
      dir("p2_1",   32'h0000_0002, 32'h0000_0001, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
      dir("p7_8",   32'h0000_0007, 32'h0000_0008, 1'b0, 32'h0000_000F, 1'b0, 1'b0);
      dir("p0_a",   32'h0000_0000, 32'h0000_000A, 1'b0, 32'h0000_000A, 1'b0, 1'b0);
      dir("chain",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

      // Idle cycles with changing operands must not disturb the held result.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b0;
         a        = $urandom;
         b        = $urandom;
         @(negedge clk);
         check_eq("hold_sum", sum, 32'h0000_0000);
         check_eq("hold_cout", 32'(cout), 32'd1);
         check_eq("hold_vld", 32'(out_valid), 32'd0);
      end

      for (int i = 0; i < 1000; i++) begin
         a        = $urandom;
         b        = $urandom;
         cin      = 1'($urandom);
         in_valid = 1'b1;
         @(negedge clk);
      end

      for (int i = 0; i < 200; i++) begin
         a        = $urandom;
         b        = $urandom;
         cin      = 1'($urandom);
         in_valid = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end

      // Asynchronous reset between clock edges while a valid result is showing.
      dir("pre_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      pipe_en = 1'b0;
      mon_en  = 1'b0;
      check_eq("pre_rst_vld", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check_zero("arst");
      @(posedge clk);
      #1;
      check_zero("arst_hold");
      @(negedge clk);
      sb_q.delete();
      m_sum    = '0;
      m_cout   = 1'b0;
      m_ovf    = 1'b0;
      in_valid = 1'b0;
      rst      = 1'b0;
      pipe_en  = 1'b1;

      dir("post_rst", 32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_000B, 1'b0, 1'b0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      pipe_en = 1'b0;
      #1;
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      mon_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
